// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared constants, FSM encoding and GF(2^8) / AES byte-level helpers used by
//   the AES-128 round datapath and its controller.
//   Contents:
//     NR, KEY_BITS        - round count and expanded-key width
//     fsm_e               - controller states
//     xtime, gmul, gf_inv - GF(2^8) arithmetic, polynomial 0x11B
//     sbox, inv_sbox      - AES byte substitution and its inverse
//     mix_col, inv_mix_col- single-column MixColumns / InvMixColumns
//     round_key           - 128-bit round key r out of the expanded key
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int NR       = 10;
    localparam int KEY_BITS = 128 * (NR + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); 0 maps to 0,
    // which is exactly what the S-box definition needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    // S-box in its algebraic form: inverse followed by the affine map
    // b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine map (rotl1 ^ rotl3 ^ rotl6 ^ 0x05), then inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Column bytes a0..a3 sit in [31:24]..[7:0].
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Round key 0 occupies the top 128 bits of the expanded key.
    function automatic logic [127:0] round_key(input logic [KEY_BITS-1:0] key,
                                               input logic [3:0]          r);
        logic [KEY_BITS-1:0] sh;
        sh = key << (128 * int'(r));
        return sh[KEY_BITS-1 -: 128];
    endfunction

endpackage

// File: rtl/aes_round.sv
// -----------------------------------------------------------------------------
// aes_round
//   Purely combinational single AES round, forward or inverse.
//   Ports:
//     state_in  [127:0] in   current state, byte i in [127-8i -: 8]
//     round_key [127:0] in   key to add this round
//     encrypt           in   1 = cipher round, 0 = inverse-cipher round
//     last              in   final round: MixColumns / InvMixColumns skipped
//     state_out [127:0] out  next state
// -----------------------------------------------------------------------------
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         encrypt,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [7:0]   s_b   [16];
    logic [7:0]   enc_b [16];
    logic [7:0]   dec_b [16];
    logic [127:0] enc_sr;
    logic [127:0] enc_mc;
    logic [127:0] dec_ark;
    logic [127:0] dec_mc;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            s_b[i] = state_in[127-8*i -: 8];
        end
        // Byte r+4c is row r, column c. ShiftRows pulls row r from column
        // c+r; InvShiftRows pulls it from column c-r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                enc_b[4*c+r] = sbox(s_b[4*((c + r) % 4) + r]);
                dec_b[4*c+r] = inv_sbox(s_b[4*((c + 4 - r) % 4) + r]);
            end
        end
        enc_sr  = '0;
        dec_ark = '0;
        for (int i = 0; i < 16; i++) begin
            enc_sr[127-8*i -: 8]  = enc_b[i];
            dec_ark[127-8*i -: 8] = dec_b[i] ^ round_key[127-8*i -: 8];
        end
        enc_mc = '0;
        dec_mc = '0;
        for (int c = 0; c < 4; c++) begin
            enc_mc[127-32*c -: 32] = mix_col(enc_sr[127-32*c -: 32]);
            dec_mc[127-32*c -: 32] = inv_mix_col(dec_ark[127-32*c -: 32]);
        end
        if (encrypt) begin
            state_out = (last ? enc_sr : enc_mc) ^ round_key;
        end else begin
            state_out = last ? dec_ark : dec_mc;
        end
    end

endmodule

// File: rtl/aes128_crypto.sv
// -----------------------------------------------------------------------------
// aes128_crypto
//   Iterative AES-128 encrypt/decrypt core, one round per clock.
//   Ports:
//     Clk, Rst            clock, synchronous active-high reset
//     i_Data     [127:0]  input block, byte 0 in [127:120]
//     i_Key      [1407:0] expanded key, rk r in [1407-128r -: 128]; must stay
//                         stable for the whole operation (not latched)
//     i_fEncrypt          1 = encrypt, 0 = decrypt, sampled with i_fStart
//     i_fStart            start request
//     o_Data     [127:0]  registered result, held until the next completion
//     o_fDone             one-cycle completion pulse
//     o_dbg_state         controller state, for observation only
//
//   Handshake: i_fStart is taken only when the controller is IDLE (this
//   includes the o_fDone cycle); while RUN it is ignored and never queued.
//   o_fDone is high for exactly one cycle, ten edges after the accepting
//   edge, and o_Data is valid in that cycle and stays until the next one.
// -----------------------------------------------------------------------------
module aes128_crypto
    import aes_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic [127:0]        i_Data,
    input  logic [KEY_BITS-1:0] i_Key,
    input  logic                i_fEncrypt,
    input  logic                i_fStart,
    output logic [127:0]        o_Data,
    output logic                o_fDone,
    output fsm_e                o_dbg_state
);

    fsm_e         fsm_q,   fsm_d;
    logic [3:0]   round_q, round_d;
    logic         enc_q,   enc_d;
    logic [127:0] state_q, state_d;
    logic [127:0] data_q,  data_d;
    logic         done_q,  done_d;

    logic         last_round;
    logic [3:0]   rk_idx;
    logic [127:0] rk_cur;
    logic [127:0] start_key;
    logic [127:0] round_out;

    // The inverse cipher walks the key schedule backwards.
    assign last_round = (round_q == 4'(NR));
    assign rk_idx     = enc_q ? round_q : 4'(NR) - round_q;
    assign rk_cur     = round_key(i_Key, rk_idx);
    assign start_key  = round_key(i_Key, i_fEncrypt ? 4'd0 : 4'(NR));

    aes_round u_round (
        .state_in  (state_q),
        .round_key (rk_cur),
        .encrypt   (enc_q),
        .last      (last_round),
        .state_out (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        enc_d   = enc_q;
        state_d = state_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (i_fStart) begin
                    enc_d   = i_fEncrypt;
                    state_d = i_Data ^ start_key;
                    round_d = 4'd1;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = round_out;
                round_d = round_q + 4'd1;
                if (last_round) begin
                    data_d  = round_out;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    fsm_d   = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fsm_q   <= ST_IDLE;
            round_q <= 4'd0;
            enc_q   <= 1'b0;
            state_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            enc_q   <= enc_d;
            state_q <= state_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign o_Data      = data_q;
    assign o_fDone     = done_q;
    assign o_dbg_state = fsm_q;

endmodule

// File: tb/tb_aes128_crypto.sv
// -----------------------------------------------------------------------------
// tb_aes128_crypto
//   Directed bench for aes128_crypto with a behavioural AES model, a
//   transaction-timing model and a per-cycle compare process.
// -----------------------------------------------------------------------------
module tb_aes128_crypto;
  import aes_pkg::KEY_BITS;
  import aes_pkg::fsm_e;
  import aes_pkg::ST_IDLE;

  localparam logic [127:0] KEY0     = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] RK10_LIT = 128'h28FDDEF86DA4244ACCC0A4FE3B316F26;
  localparam logic [127:0] PT       = 128'h54776F204F6E65204E696E652054776F;
  localparam logic [127:0] CT       = 128'h29C3505F571420F6402299B31A02D73A;
  localparam logic [7:0]   AFF_C    = 8'h63;

  // ---------------- clock / reset / DUT ----------------
  logic                Clk = 1'b0;
  logic                Rst;
  logic [127:0]        i_Data;
  logic [KEY_BITS-1:0] i_Key;
  logic                i_fEncrypt;
  logic                i_fStart;
  logic [127:0]        o_Data;
  logic                o_fDone;
  fsm_e                o_dbg_state;

  always #5 Clk = ~Clk;

  aes128_crypto dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .i_Data      (i_Data),
    .i_Key       (i_Key),
    .i_fEncrypt  (i_fEncrypt),
    .i_fStart    (i_fStart),
    .o_Data      (o_Data),
    .o_fDone     (o_fDone),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec      = 0;
  int n_fail     = 0;
  int edge_n     = 0;
  int start_edge = 0;
  int done_count = 0;
  int free_edge  = 0;
  int lat;
  int dc0;
  bit model_on   = 1'b0;
  bit exp_done   = 1'b0;
  logic [127:0] exp_data = '0;
  logic [127:0] exp_q[$];
  int           exp_edge_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural AES model ----------------
  logic [7:0]   sbox_t [256];
  logic [7:0]   inv_t  [256];
  logic [127:0] rk     [11];

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11B << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ AFF_C[i];
      sbox_t[x] = s;
      inv_t[s]  = 8'(x);
    end
  endtask

  task automatic expand_key();
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = KEY0[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      i_Key[KEY_BITS-1-128*r -: 128] = rk[r];
    end
  endtask

  function automatic logic [127:0] m_sub(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_t[v[127-8*i -: 8]] : sbox_t[v[127-8*i -: 8]];
    return o;
  endfunction

  // Row r rotates left by r (forward) or right by r (inverse).
  function automatic logic [127:0] m_shift(input logic [127:0] v, input bit inv);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv) t[r + 4*c] = s[r + 4*((c + r) % 4)];
        else      t[r + 4*((c + r) % 4)] = s[r + 4*c];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  // Circulant matrix multiply per column.
  function automatic logic [127:0] m_mix(input logic [127:0] v, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (!inv) begin coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1; end
    else      begin coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gm(coef[(k - r + 4) % 4], v[127-8*(4*c+k) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] din, input logic enc);
    logic [127:0] v;
    if (enc) begin
      v = din ^ rk[0];
      for (int rnd = 1; rnd <= 10; rnd++) begin
        v = m_shift(m_sub(v, 1'b0), 1'b0);
        if (rnd < 10) v = m_mix(v, 1'b0);
        v = v ^ rk[rnd];
      end
    end else begin
      v = din ^ rk[10];
      for (int rnd = 9; rnd >= 0; rnd--) begin
        v = m_sub(m_shift(v, 1'b1), 1'b1) ^ rk[rnd];
        if (rnd > 0) v = m_mix(v, 1'b1);
      end
    end
    return v;
  endfunction

  // ---------------- transaction-timing model ----------------
  // A start is accepted unless an operation is in flight; its result is
  // due 10 edges later and the next start can be taken one edge after that.
  initial begin
    forever begin
      @(posedge Clk);
      edge_n++;
      if (Rst) begin
        exp_q.delete();
        exp_edge_q.delete();
        exp_data  = '0;
        exp_done  = 1'b0;
        free_edge = 0;
        model_on  = 1'b1;
      end else if (model_on) begin
        if (i_fStart && edge_n >= free_edge) begin
          exp_q.push_back(aes_model(i_Data, i_fEncrypt));
          exp_edge_q.push_back(edge_n + 10);
          free_edge = edge_n + 11;
        end
        exp_done = 1'b0;
        if (exp_edge_q.size() > 0 && exp_edge_q[0] == edge_n) begin
          exp_data = exp_q.pop_front();
          void'(exp_edge_q.pop_front());
          exp_done = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge Clk);
      if (model_on) begin
        check("cyc_o_fDone", 128'(o_fDone), 128'(exp_done));
        check("cyc_o_Data", o_Data, exp_data);
        if (o_fDone === 1'b1) done_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [127:0] d, input logic enc);
    i_Data     = d;
    i_fEncrypt = enc;
    i_fStart   = 1'b1;
    @(posedge Clk);
    #1;
    start_edge = edge_n;
    i_fStart   = 1'b0;
  endtask

  task automatic wait_done(input string name, output int l);
    l = -1;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk);
      #1;
      if (o_fDone === 1'b1) begin
        l = edge_n - start_edge;
        break;
      end
    end
    if (l < 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: o_fDone absent after 30 cycles, expected at 10", name);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    Rst        = 1'b1;
    i_fStart   = 1'b0;
    i_Data     = '0;
    i_fEncrypt = 1'b0;
    i_Key      = '0;
    build_tables();
    expand_key();

    // Hand-computed literals pinning the model.
    check("model_sbox_00", 128'(sbox_t[8'h00]), 128'h63);
    check("model_sbox_53", 128'(sbox_t[8'h53]), 128'hED);
    check("model_rk0", rk[0], KEY0);
    check("model_rk1_w0", 128'(rk[1][127:96]), 128'hE232FCF1);
    check("model_rk10", rk[10], RK10_LIT);
    check("model_enc", aes_model(PT, 1'b1), CT);
    check("model_dec", aes_model(CT, 1'b0), PT);

    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check("reset_o_Data", o_Data, 128'h0);
    check("reset_o_fDone", 128'(o_fDone), 128'h0);
    check("reset_state", 128'(o_dbg_state), 128'(ST_IDLE));

    // 1) encrypt + 6) pulse width and hold
    idle(1);
    start_op(PT, 1'b1);
    wait_done("t1_done", lat);
    check("t1_latency", 128'(lat), 128'd10);
    check("t1_data", o_Data, CT);
    idle(1);
    check("t6_done_width", 128'(o_fDone), 128'h0);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      check("t6_hold", o_Data, CT);
    end

    // 2) decrypt
    start_op(CT, 1'b0);
    wait_done("t2_done", lat);
    check("t2_latency", 128'(lat), 128'd10);
    check("t2_data", o_Data, PT);
    idle(3);

    // 3) start pulse at E5 is ignored
    dc0 = done_count;
    start_op(PT, 1'b1);
    idle(4);
    i_Data     = CT;
    i_fEncrypt = 1'b0;
    i_fStart   = 1'b1;
    idle(1);
    i_fStart   = 1'b0;
    wait_done("t3_done", lat);
    check("t3_latency", 128'(lat), 128'd10);
    check("t3_data", o_Data, CT);
    idle(15);
    check("t3_done_pulses", 128'(done_count - dc0), 128'd1);

    // 4) reset sampled at E4 aborts
    start_op(PT, 1'b1);
    idle(3);
    Rst = 1'b1;
    idle(1);
    Rst = 1'b0;
    check("t4_o_Data", o_Data, 128'h0);
    check("t4_o_fDone", 128'(o_fDone), 128'h0);
    dc0 = done_count;
    idle(15);
    check("t4_no_done", 128'(done_count - dc0), 128'd0);
    start_op(PT, 1'b1);
    wait_done("t4_fresh_done", lat);
    check("t4_fresh_latency", 128'(lat), 128'd10);
    check("t4_fresh_data", o_Data, CT);
    idle(2);

    // 5) back-to-back: decrypt launched in the o_fDone cycle
    start_op(PT, 1'b1);
    wait_done("t5_enc_done", lat);
    check("t5_enc_data", o_Data, CT);
    i_Data     = CT;
    i_fEncrypt = 1'b0;
    i_fStart   = 1'b1;
    @(posedge Clk);
    #1;
    start_edge = edge_n;
    i_fStart   = 1'b0;
    wait_done("t5_dec_done", lat);
    check("t5_dec_latency", 128'(lat), 128'd10);
    check("t5_dec_data", o_Data, PT);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
